// File: rtl/frame_receiver.sv
// frame_receiver: measures one-way delay of probe frames on the MAC RX client byte stream.
// Define FRAME_RECEIVER_MINMAX_EN to build min_delay/max_delay tracking.
module frame_receiver #(
    parameter logic [15:0] ETHERTYPE    = 16'h88B5,
    parameter int          STAMP_OFFSET = 14,
    parameter int          CNT_WIDTH    = 16
) (
    input  logic                 rx_clk,
    input  logic                 reset_n,
    input  logic [31:0]          cur_time,
    input  logic [7:0]           mac_rx_data,
    input  logic                 mac_rx_dvld,
    input  logic                 mac_rx_goodframe,
    input  logic                 mac_rx_badframe,
    input  logic                 clear_stats,
    output logic [31:0]          delay_value,
    output logic                 delay_valid,
    output logic [CNT_WIDTH-1:0] good_frame_cnt,
    output logic [CNT_WIDTH-1:0] bad_frame_cnt,
    output logic [CNT_WIDTH-1:0] probe_frame_cnt
`ifdef FRAME_RECEIVER_MINMAX_EN
    ,
    output logic [31:0]          min_delay,
    output logic [31:0]          max_delay
`endif
);

    typedef enum logic [2:0] {IDLE, HDR, STAMP, PAYLOAD, WAIT_STATUS} state_t;

    localparam logic [5:0]           STAMP_FIRST = 6'(STAMP_OFFSET);
    localparam logic [5:0]           STAMP_LAST  = 6'(STAMP_OFFSET + 3);
    localparam logic [5:0]           MIN_LEN     = 6'(STAMP_OFFSET + 4);
    localparam logic [5:0]           IDX_MAX     = 6'd63;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

    state_t      state;
    logic [5:0]  byte_idx;
    logic [31:0] arrival_time;
    logic [31:0] tx_stamp;
    logic        is_probe;
    logic        type_hi_ok;
    logic        armed;

    logic        frame_end;
    logic        in_status;
    logic        probe_ok;
    logic        start;
    logic        accept_good;
    logic        accept_bad;
    logic        lost;
    logic        inc_good;
    logic        inc_bad;
    logic        inc_probe;
    logic [31:0] new_delay;

    // A status pulse on the dvld falling cycle is handled as if already in WAIT_STATUS;
    // byte_idx still holds the received length there, so the runt check applies directly.
    always_comb begin
        frame_end   = (state inside {HDR, STAMP, PAYLOAD}) && !mac_rx_dvld;
        in_status   = (state == WAIT_STATUS) || frame_end;
        probe_ok    = is_probe && (byte_idx >= MIN_LEN);
        accept_good = in_status && mac_rx_goodframe;
        accept_bad  = in_status && !mac_rx_goodframe && mac_rx_badframe;
        lost        = (state == WAIT_STATUS) && mac_rx_dvld && !mac_rx_goodframe && !mac_rx_badframe;
        start       = mac_rx_dvld && (((state == IDLE) && armed) || (state == WAIT_STATUS));
        inc_good    = accept_good;
        inc_bad     = accept_bad || lost;
        inc_probe   = accept_good && probe_ok;
        new_delay   = arrival_time - tx_stamp;
    end

    // armed stays low after reset until dvld is seen low, so a frame cut by reset is never picked up.
    always_ff @(posedge rx_clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            byte_idx     <= '0;
            arrival_time <= '0;
            tx_stamp     <= '0;
            is_probe     <= 1'b0;
            type_hi_ok   <= 1'b0;
            armed        <= 1'b0;
            delay_value  <= '0;
            delay_valid  <= 1'b0;
        end else begin
            delay_valid <= 1'b0;
            if (!mac_rx_dvld) begin
                armed <= 1'b1;
            end
            if (inc_probe) begin
                delay_value <= new_delay;
                delay_valid <= 1'b1;
            end
            if (start) begin
                state        <= HDR;
                byte_idx     <= 6'd1;
                arrival_time <= cur_time;
                is_probe     <= 1'b0;
                type_hi_ok   <= 1'b0;
            end else begin
                case (state)
                    HDR, STAMP, PAYLOAD: begin
                        if (!mac_rx_dvld) begin
                            if (byte_idx < MIN_LEN) begin
                                is_probe <= 1'b0;
                            end
                            state <= (mac_rx_goodframe || mac_rx_badframe) ? IDLE : WAIT_STATUS;
                        end else begin
                            if (byte_idx != IDX_MAX) begin
                                byte_idx <= byte_idx + 6'd1;
                            end
                            if (byte_idx == 6'd12) begin
                                type_hi_ok <= (mac_rx_data == ETHERTYPE[15:8]);
                            end
                            if (byte_idx == 6'd13) begin
                                is_probe <= type_hi_ok && (mac_rx_data == ETHERTYPE[7:0]);
                            end
                            if ((byte_idx >= STAMP_FIRST) && (byte_idx <= STAMP_LAST)) begin
                                tx_stamp <= {tx_stamp[23:0], mac_rx_data};
                            end
                            if ((state == HDR) && (byte_idx == STAMP_FIRST)) begin
                                state <= STAMP;
                            end
                            if ((state == STAMP) && (byte_idx == STAMP_LAST)) begin
                                state <= PAYLOAD;
                            end
                        end
                    end
                    WAIT_STATUS: begin
                        if (mac_rx_goodframe || mac_rx_badframe) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // A clear wins over any increment in the same cycle.
    always_ff @(posedge rx_clk or negedge reset_n) begin
        if (!reset_n) begin
            good_frame_cnt  <= '0;
            bad_frame_cnt   <= '0;
            probe_frame_cnt <= '0;
        end else if (clear_stats) begin
            good_frame_cnt  <= '0;
            bad_frame_cnt   <= '0;
            probe_frame_cnt <= '0;
        end else begin
            if (inc_good && (good_frame_cnt != CNT_MAX)) begin
                good_frame_cnt <= good_frame_cnt + CNT_ONE;
            end
            if (inc_bad && (bad_frame_cnt != CNT_MAX)) begin
                bad_frame_cnt <= bad_frame_cnt + CNT_ONE;
            end
            if (inc_probe && (probe_frame_cnt != CNT_MAX)) begin
                probe_frame_cnt <= probe_frame_cnt + CNT_ONE;
            end
        end
    end

`ifdef FRAME_RECEIVER_MINMAX_EN
    always_ff @(posedge rx_clk or negedge reset_n) begin
        if (!reset_n) begin
            min_delay <= 32'hFFFF_FFFF;
            max_delay <= '0;
        end else if (clear_stats) begin
            min_delay <= 32'hFFFF_FFFF;
            max_delay <= '0;
        end else if (inc_probe) begin
            if (new_delay < min_delay) begin
                min_delay <= new_delay;
            end
            if (new_delay > max_delay) begin
                max_delay <= new_delay;
            end
        end
    end
`else
    // Without min/max tracking the delay is reported only through delay_value.
`endif

endmodule

// File: tb/tb_frame_receiver.sv
// tb_frame_receiver: directed and randomized checks of frame_receiver against a frame-level model.
// Honours FRAME_RECEIVER_MINMAX_EN for the optional min/max ports.
module tb_frame_receiver;

    localparam logic [15:0] ETHERTYPE    = 16'h88B5;
    localparam int          STAMP_OFFSET = 14;

    logic        rx_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] cur_time = '0;
    logic [7:0]  mac_rx_data = '0;
    logic        mac_rx_dvld = 1'b0;
    logic        mac_rx_goodframe = 1'b0;
    logic        mac_rx_badframe = 1'b0;
    logic        clear_stats = 1'b0;

    logic [31:0] delay_value;
    logic        delay_valid;
    logic [15:0] good_frame_cnt;
    logic [15:0] bad_frame_cnt;
    logic [15:0] probe_frame_cnt;

    logic [31:0] sm_delay_value;
    logic        sm_delay_valid;
    logic [3:0]  sm_good_cnt;
    logic [3:0]  sm_bad_cnt;
    logic [3:0]  sm_probe_cnt;

`ifdef FRAME_RECEIVER_MINMAX_EN
    logic [31:0] min_delay, max_delay, sm_min_delay, sm_max_delay;
    logic [31:0] exp_min = 32'hFFFF_FFFF;
    logic [31:0] exp_max = '0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    int exp_good = 0;
    int exp_bad = 0;
    int exp_probe = 0;
    int exp_sm_good = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];

    frame_receiver #(.ETHERTYPE(ETHERTYPE), .STAMP_OFFSET(STAMP_OFFSET), .CNT_WIDTH(16)) dut (
        .rx_clk(rx_clk), .reset_n(reset_n), .cur_time(cur_time),
        .mac_rx_data(mac_rx_data), .mac_rx_dvld(mac_rx_dvld),
        .mac_rx_goodframe(mac_rx_goodframe), .mac_rx_badframe(mac_rx_badframe),
        .clear_stats(clear_stats), .delay_value(delay_value), .delay_valid(delay_valid),
        .good_frame_cnt(good_frame_cnt), .bad_frame_cnt(bad_frame_cnt),
        .probe_frame_cnt(probe_frame_cnt)
`ifdef FRAME_RECEIVER_MINMAX_EN
        , .min_delay(min_delay), .max_delay(max_delay)
`endif
    );

    // Narrow-counter copy so saturation can be reached in a few cycles.
    frame_receiver #(.ETHERTYPE(ETHERTYPE), .STAMP_OFFSET(STAMP_OFFSET), .CNT_WIDTH(4)) dut_small (
        .rx_clk(rx_clk), .reset_n(reset_n), .cur_time(cur_time),
        .mac_rx_data(mac_rx_data), .mac_rx_dvld(mac_rx_dvld),
        .mac_rx_goodframe(mac_rx_goodframe), .mac_rx_badframe(mac_rx_badframe),
        .clear_stats(clear_stats), .delay_value(sm_delay_value), .delay_valid(sm_delay_valid),
        .good_frame_cnt(sm_good_cnt), .bad_frame_cnt(sm_bad_cnt),
        .probe_frame_cnt(sm_probe_cnt)
`ifdef FRAME_RECEIVER_MINMAX_EN
        , .min_delay(sm_min_delay), .max_delay(sm_max_delay)
`endif
    );

    always #5 rx_clk = ~rx_clk;

    always @(negedge rx_clk) begin
        if (delay_valid === 1'b1) got_q.push_back(delay_value);
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge rx_clk);
        #1;
    endtask

    function automatic int sat(input int v, input int maxv);
        return (v >= maxv) ? maxv : v + 1;
    endfunction

    task automatic model_clear();
        exp_good = 0; exp_bad = 0; exp_probe = 0; exp_sm_good = 0;
`ifdef FRAME_RECEIVER_MINMAX_EN
        exp_min = 32'hFFFF_FFFF; exp_max = '0;
`endif
    endtask

    // status: 1 good, 2 bad, 3 lost (next frame started without status)
    task automatic model_frame(input int len, input logic [15:0] et, input logic [31:0] st,
                               input logic [31:0] arr, input int status, input bit clr);
        bit probe;
        logic [31:0] d;
        probe = (len >= STAMP_OFFSET + 4) && (et == ETHERTYPE);
        d = arr - st;
        if (status == 1 && probe) exp_q.push_back(d);
        if (clr) begin
            model_clear();
        end else if (status == 1) begin
            exp_good = sat(exp_good, 65535);
            exp_sm_good = sat(exp_sm_good, 15);
            if (probe) begin
                exp_probe = sat(exp_probe, 65535);
`ifdef FRAME_RECEIVER_MINMAX_EN
                if (d < exp_min) exp_min = d;
                if (d > exp_max) exp_max = d;
`endif
            end
        end else if (status == 2 || status == 3) begin
            exp_bad = sat(exp_bad, 65535);
        end
    endtask

    task automatic frame_bytes(input int len, input logic [15:0] et, input logic [31:0] st,
                               input logic [31:0] arr, input int pend);
        logic [7:0] b;
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            if (i == 12) b = et[15:8];
            else if (i == 13) b = et[7:0];
            else if (i >= STAMP_OFFSET && i < STAMP_OFFSET + 4)
                b = 8'(st >> (8 * (STAMP_OFFSET + 3 - i)));
            mac_rx_data = b;
            mac_rx_dvld = 1'b1;
            cur_time = arr + 32'(i);
            mac_rx_goodframe = (i == 0) && (pend == 1);
            mac_rx_badframe  = (i == 0) && (pend == 2);
            tick();
        end
        mac_rx_goodframe = 1'b0;
        mac_rx_badframe  = 1'b0;
    endtask

    task automatic end_frame(input int status, input int gap, input bit clr);
        mac_rx_dvld = 1'b0;
        repeat (gap) tick();
        mac_rx_goodframe = (status == 1);
        mac_rx_badframe  = (status == 2);
        clear_stats      = clr;
        tick();
        mac_rx_goodframe = 1'b0;
        mac_rx_badframe  = 1'b0;
        clear_stats      = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (delay_value !== 32'h0 || delay_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_delay: got value=%h valid=%b, expected 0/0", delay_value, delay_valid);
        end
        n_checks++;
        if (good_frame_cnt !== 16'h0 || bad_frame_cnt !== 16'h0 || probe_frame_cnt !== 16'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_counters: got good=%0d bad=%0d probe=%0d, expected 0",
                     good_frame_cnt, bad_frame_cnt, probe_frame_cnt);
        end
`ifdef FRAME_RECEIVER_MINMAX_EN
        n_checks++;
        if (min_delay !== 32'hFFFF_FFFF || max_delay !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_minmax: got min=%h max=%h, expected ffffffff/0", min_delay, max_delay);
        end
`endif
        reset_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_probe();
        frame_bytes(64, ETHERTYPE, 32'h0000_1000, 32'h0000_1234, 0);
        end_frame(1, 1, 1'b0);
        model_frame(64, ETHERTYPE, 32'h0000_1000, 32'h0000_1234, 1, 1'b0);
        n_checks++;
        if (delay_valid !== 1'b1 || delay_value !== 32'h0000_0234) begin
            n_fail++;
            $display("[TB] FAIL probe_pulse: got valid=%b value=%h, expected 1/00000234", delay_valid, delay_value);
        end
        tick();
        n_checks++;
        if (delay_valid !== 1'b0 || delay_value !== 32'h0000_0234) begin
            n_fail++;
            $display("[TB] FAIL probe_hold: got valid=%b value=%h, expected 0/00000234", delay_valid, delay_value);
        end
        n_checks++;
        if (good_frame_cnt !== 16'(exp_good) || probe_frame_cnt !== 16'(exp_probe)) begin
            n_fail++;
            $display("[TB] FAIL probe_counts: got good=%0d probe=%0d, expected %0d/%0d",
                     good_frame_cnt, probe_frame_cnt, exp_good, exp_probe);
        end
    endtask

    task automatic test_wraparound();
        frame_bytes(40, ETHERTYPE, 32'hFFFF_FFF0, 32'h0000_0010, 0);
        end_frame(1, 2, 1'b0);
        model_frame(40, ETHERTYPE, 32'hFFFF_FFF0, 32'h0000_0010, 1, 1'b0);
        tick();
        n_checks++;
        if (got_q.size() !== exp_q.size() || got_q[$] !== 32'h0000_0020) begin
            n_fail++;
            $display("[TB] FAIL wraparound: got %0d pulses last=%h, expected %0d pulses last=00000020",
                     got_q.size(), got_q[$], exp_q.size());
        end
    endtask

    task automatic test_non_probe_and_bad();
        frame_bytes(60, 16'h0800, 32'h0, 32'h100, 0);
        end_frame(1, 1, 1'b0);
        model_frame(60, 16'h0800, 32'h0, 32'h100, 1, 1'b0);
        frame_bytes(60, ETHERTYPE, 32'h50, 32'h500, 0);
        end_frame(2, 1, 1'b0);
        model_frame(60, ETHERTYPE, 32'h50, 32'h500, 2, 1'b0);
        tick();
        n_checks++;
        if (good_frame_cnt !== 16'(exp_good) || bad_frame_cnt !== 16'(exp_bad) ||
            probe_frame_cnt !== 16'(exp_probe) || got_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("[TB] FAIL non_probe_bad: got good=%0d bad=%0d probe=%0d pulses=%0d, expected %0d/%0d/%0d/%0d",
                     good_frame_cnt, bad_frame_cnt, probe_frame_cnt, got_q.size(),
                     exp_good, exp_bad, exp_probe, exp_q.size());
        end
    endtask

    task automatic test_runt();
        frame_bytes(16, ETHERTYPE, 32'h10, 32'h900, 0);
        end_frame(1, 1, 1'b0);
        model_frame(16, ETHERTYPE, 32'h10, 32'h900, 1, 1'b0);
        frame_bytes(17, ETHERTYPE, 32'h10, 32'h900, 0);
        end_frame(1, 0, 1'b0);
        model_frame(17, ETHERTYPE, 32'h10, 32'h900, 1, 1'b0);
        tick();
        n_checks++;
        if (good_frame_cnt !== 16'(exp_good) || probe_frame_cnt !== 16'(exp_probe) ||
            got_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("[TB] FAIL runt: got good=%0d probe=%0d pulses=%0d, expected %0d/%0d/%0d",
                     good_frame_cnt, probe_frame_cnt, got_q.size(), exp_good, exp_probe, exp_q.size());
        end
    endtask

    task automatic test_lost_frame();
        frame_bytes(30, 16'h0800, 32'h0, 32'h0, 0);
        mac_rx_dvld = 1'b0;
        tick();
        model_frame(30, 16'h0800, 32'h0, 32'h0, 3, 1'b0);
        frame_bytes(50, ETHERTYPE, 32'h0000_0500, 32'h0000_0777, 0);
        end_frame(1, 1, 1'b0);
        model_frame(50, ETHERTYPE, 32'h0000_0500, 32'h0000_0777, 1, 1'b0);
        tick();
        n_checks++;
        if (bad_frame_cnt !== 16'(exp_bad) || good_frame_cnt !== 16'(exp_good)) begin
            n_fail++;
            $display("[TB] FAIL lost_counts: got bad=%0d good=%0d, expected %0d/%0d",
                     bad_frame_cnt, good_frame_cnt, exp_bad, exp_good);
        end
        n_checks++;
        if (got_q[$] !== 32'h0000_0277) begin
            n_fail++;
            $display("[TB] FAIL lost_next_delay: got %h, expected 00000277", got_q[$]);
        end
    endtask

    task automatic test_back_to_back();
        frame_bytes(40, ETHERTYPE, 32'h0000_0100, 32'h0000_1100, 0);
        mac_rx_dvld = 1'b0;
        tick();
        model_frame(40, ETHERTYPE, 32'h0000_0100, 32'h0000_1100, 1, 1'b0);
        frame_bytes(30, ETHERTYPE, 32'h0000_2000, 32'h0000_2ABC, 1);
        end_frame(1, 0, 1'b0);
        model_frame(30, ETHERTYPE, 32'h0000_2000, 32'h0000_2ABC, 1, 1'b0);
        tick();
        n_checks++;
        if (bad_frame_cnt !== 16'(exp_bad) || good_frame_cnt !== 16'(exp_good) ||
            probe_frame_cnt !== 16'(exp_probe)) begin
            n_fail++;
            $display("[TB] FAIL b2b_counts: got bad=%0d good=%0d probe=%0d, expected %0d/%0d/%0d",
                     bad_frame_cnt, good_frame_cnt, probe_frame_cnt, exp_bad, exp_good, exp_probe);
        end
        n_checks++;
        if (got_q.size() < 2 || got_q[got_q.size()-2] !== 32'h0000_1000 || got_q[$] !== 32'h0000_0ABC) begin
            n_fail++;
            $display("[TB] FAIL b2b_delays: got last=%h pulses=%0d, expected 00001000 then 00000abc",
                     got_q[$], got_q.size());
        end
    endtask

    task automatic test_idle_status();
        mac_rx_goodframe = 1'b1;
        tick();
        mac_rx_goodframe = 1'b0;
        mac_rx_badframe  = 1'b1;
        tick();
        mac_rx_badframe  = 1'b0;
        tick();
        n_checks++;
        if (good_frame_cnt !== 16'(exp_good) || bad_frame_cnt !== 16'(exp_bad)) begin
            n_fail++;
            $display("[TB] FAIL idle_status: got good=%0d bad=%0d, expected %0d/%0d",
                     good_frame_cnt, bad_frame_cnt, exp_good, exp_bad);
        end
    endtask

    task automatic test_saturation();
        pulse_clear();
        for (int i = 0; i < 15; i++) begin
            frame_bytes(2, 16'h0800, 32'h0, 32'h0, 0);
            end_frame(1, 0, 1'b0);
            model_frame(2, 16'h0800, 32'h0, 32'h0, 1, 1'b0);
        end
        n_checks++;
        if (sm_good_cnt !== 4'(exp_sm_good)) begin
            n_fail++;
            $display("[TB] FAIL sat_reach: got %0d, expected %0d", sm_good_cnt, exp_sm_good);
        end
        frame_bytes(2, 16'h0800, 32'h0, 32'h0, 0);
        end_frame(1, 0, 1'b0);
        model_frame(2, 16'h0800, 32'h0, 32'h0, 1, 1'b0);
        n_checks++;
        if (sm_good_cnt !== 4'hF || good_frame_cnt !== 16'(exp_good)) begin
            n_fail++;
            $display("[TB] FAIL sat_hold: got small=%0d wide=%0d, expected 15/%0d",
                     sm_good_cnt, good_frame_cnt, exp_good);
        end
    endtask

    task automatic test_clear_collision();
        frame_bytes(20, ETHERTYPE, 32'h0000_0001, 32'h0000_0065, 0);
        end_frame(1, 1, 1'b1);
        model_frame(20, ETHERTYPE, 32'h0000_0001, 32'h0000_0065, 1, 1'b1);
        tick();
        n_checks++;
        if (good_frame_cnt !== 16'h0 || probe_frame_cnt !== 16'h0 || sm_good_cnt !== 4'h0) begin
            n_fail++;
            $display("[TB] FAIL clear_collision: got good=%0d probe=%0d small=%0d, expected 0",
                     good_frame_cnt, probe_frame_cnt, sm_good_cnt);
        end
        n_checks++;
        if (got_q.size() !== exp_q.size() || got_q[$] !== 32'h0000_0064) begin
            n_fail++;
            $display("[TB] FAIL clear_keeps_delay: got pulses=%0d last=%h, expected %0d/00000064",
                     got_q.size(), got_q[$], exp_q.size());
        end
    endtask

`ifdef FRAME_RECEIVER_MINMAX_EN
    task automatic test_minmax();
        int d[3] = '{300, 100, 200};
        pulse_clear();
        foreach (d[i]) begin
            frame_bytes(64, ETHERTYPE, 32'd1000, 32'(1000 + d[i]), 0);
            end_frame(1, 1, 1'b0);
            model_frame(64, ETHERTYPE, 32'd1000, 32'(1000 + d[i]), 1, 1'b0);
        end
        n_checks++;
        if (min_delay !== 32'd100 || max_delay !== 32'd300) begin
            n_fail++;
            $display("[TB] FAIL minmax: got min=%0d max=%0d, expected 100/300", min_delay, max_delay);
        end
        pulse_clear();
        n_checks++;
        if (min_delay !== 32'hFFFF_FFFF || max_delay !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL minmax_clear: got min=%h max=%h, expected ffffffff/0", min_delay, max_delay);
        end
    endtask
`endif

    task automatic test_reset_mid_frame();
        int pulses;
        frame_bytes(10, ETHERTYPE, 32'h0, 32'h0, 0);
        reset_n = 1'b0;
        tick();
        tick();
        model_clear();
        n_checks++;
        if (delay_value !== 32'h0 || good_frame_cnt !== 16'h0) begin
            n_fail++;
            $display("[TB] FAIL midreset_clear: got value=%h good=%0d, expected 0/0", delay_value, good_frame_cnt);
        end
        reset_n = 1'b1;
        pulses = got_q.size();
        frame_bytes(40, ETHERTYPE, 32'h0000_0010, 32'h0000_0020, 0);
        end_frame(1, 1, 1'b0);
        tick();
        n_checks++;
        if (good_frame_cnt !== 16'h0 || bad_frame_cnt !== 16'h0 || probe_frame_cnt !== 16'h0 ||
            got_q.size() !== pulses) begin
            n_fail++;
            $display("[TB] FAIL midreset_partial: got good=%0d bad=%0d probe=%0d pulses=%0d, expected 0/0/0/%0d",
                     good_frame_cnt, bad_frame_cnt, probe_frame_cnt, got_q.size(), pulses);
        end
        frame_bytes(64, ETHERTYPE, 32'h0000_0040, 32'h0000_1040, 0);
        end_frame(1, 1, 1'b0);
        model_frame(64, ETHERTYPE, 32'h0000_0040, 32'h0000_1040, 1, 1'b0);
        tick();
        n_checks++;
        if (probe_frame_cnt !== 16'(exp_probe) || got_q[$] !== 32'h0000_1000) begin
            n_fail++;
            $display("[TB] FAIL midreset_next: got probe=%0d delay=%h, expected %0d/00001000",
                     probe_frame_cnt, got_q[$], exp_probe);
        end
    endtask

    task automatic test_random();
        int pend = 0;
        int len, mode, kind;
        logic [15:0] et;
        logic [31:0] st, arr;
        for (int k = 0; k < 40; k++) begin
            len = $urandom_range(1, 80);
            case ($urandom_range(0, 4))
                0, 1:    et = ETHERTYPE;
                2:       et = 16'h0800;
                3:       et = 16'h88B4;
                default: et = 16'h00B5;
            endcase
            st   = $urandom;
            arr  = $urandom;
            mode = $urandom_range(0, 3);
            kind = $urandom_range(1, 2);
            if (k == 39 && mode == 3) mode = 1;
            frame_bytes(len, et, st, arr, pend);
            pend = 0;
            case (mode)
                0: end_frame(kind, 0, 1'b0);
                1: end_frame(kind, $urandom_range(1, 3), 1'b0);
                2: begin
                    mac_rx_dvld = 1'b0;
                    tick();
                    pend = kind;
                end
                default: begin
                    mac_rx_dvld = 1'b0;
                    tick();
                    kind = 3;
                end
            endcase
            model_frame(len, et, st, arr, kind, 1'b0);
        end
        if (pend != 0) end_frame(pend, 0, 1'b0);
        tick();
        tick();
        n_checks++;
        if (good_frame_cnt !== 16'(exp_good) || bad_frame_cnt !== 16'(exp_bad) ||
            probe_frame_cnt !== 16'(exp_probe)) begin
            n_fail++;
            $display("[TB] FAIL random_counts: got good=%0d bad=%0d probe=%0d, expected %0d/%0d/%0d",
                     good_frame_cnt, bad_frame_cnt, probe_frame_cnt, exp_good, exp_bad, exp_probe);
        end
        n_checks++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("[TB] FAIL random_pulses: got %0d delay_valid pulses, expected %0d", got_q.size(), exp_q.size());
        end
`ifdef FRAME_RECEIVER_MINMAX_EN
        n_checks++;
        if (min_delay !== exp_min || max_delay !== exp_max) begin
            n_fail++;
            $display("[TB] FAIL random_minmax: got min=%h max=%h, expected %h/%h", min_delay, max_delay, exp_min, exp_max);
        end
`endif
    endtask

    task automatic test_delay_sequence();
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("[TB] FAIL delay_seq[%0d]: got %h, expected %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_probe();
        test_wraparound();
        test_non_probe_and_bad();
        test_runt();
        test_lost_frame();
        test_back_to_back();
        test_idle_status();
        test_saturation();
        test_clear_collision();
`ifdef FRAME_RECEIVER_MINMAX_EN
        test_minmax();
`endif
        test_reset_mid_frame();
        test_random();
        test_delay_sequence();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
